// File: rtl/sync_gen_pkg.sv
// sync_gen shared types and helpers.
// Optional pulse counter build macro: SYNC_GEN_PULSE_CNT_EN.
package sync_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RUNNING = 2'b10
  } state_t;

  // Shortest period that still leaves at least one low cycle.
  function automatic logic [31:0] eff_period(
    input logic [31:0] p,
    input logic [31:0] pw
  );
    return (p > pw) ? p : pw + 32'd1;
  endfunction

endpackage

// File: rtl/sync_gen_if.sv
// sync_gen control/status bundle.
// Optional pulse counter build macro: SYNC_GEN_PULSE_CNT_EN.
interface sync_gen_if #(
  parameter int PERIOD_WIDTH    = 16,
  parameter int PULSE_CNT_WIDTH = 32
);

  logic                       arm;
  logic                       stop;
  logic                       sync_in;
  logic [PERIOD_WIDTH-1:0]    period;
  logic                       sync_out;
  logic                       count_en;
  logic                       count_rst;
  logic                       armed;
  logic                       running;
  logic [PULSE_CNT_WIDTH-1:0] pulse_cnt;

  modport master (
    output arm, stop, sync_in, period,
    input  sync_out, count_en, count_rst,
    input  armed, running, pulse_cnt
  );

  modport slave (
    input  arm, stop, sync_in, period,
    output sync_out, count_en, count_rst,
    output armed, running, pulse_cnt
  );

endinterface

// File: rtl/sync_gen_edge_detect.sv
// Registered rising-edge detector for sync_in.
// Optional pulse counter build macro: SYNC_GEN_PULSE_CNT_EN.
module sync_gen_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember the previous sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/sync_gen.sv
// Periodic sync-pulse generator driving a downstream counter.
// Optional pulse counter build macro: SYNC_GEN_PULSE_CNT_EN.
module sync_gen
  import sync_gen_pkg::*;
#(
  parameter string ARCHITECTURE    = "BEHAVIORAL",
  parameter int    PERIOD_WIDTH    = 16,
  parameter int    PULSE_WIDTH     = 1,
  parameter int    PULSE_CNT_WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  sync_gen_if.slave bus
);

  localparam logic [31:0] PW32 =
    32'(PULSE_WIDTH);
  localparam logic [PERIOD_WIDTH-1:0] PW_P =
    PERIOD_WIDTH'(PULSE_WIDTH);
  localparam logic [PERIOD_WIDTH-1:0] ONE =
    PERIOD_WIDTH'(1);

  // Vendor-primitive variants are not populated.
  if (ARCHITECTURE == "VIRTEX5" ||
      ARCHITECTURE == "VIRTEX6") begin : g_vendor
  end

  state_t                  state_q;
  state_t                  state_d;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] period_d;
  logic [PERIOD_WIDTH-1:0] phase_q;
  logic [PERIOD_WIDTH-1:0] phase_d;
  logic [PERIOD_WIDTH-1:0] eff;
  logic [PERIOD_WIDTH-1:0] last;
  logic                    rise;
  logic                    running;
  logic                    wrap;

  sync_gen_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sync_in),
    .rise (rise)
  );

  assign eff = PERIOD_WIDTH'(
    eff_period(32'(period_q), PW32));
  assign last    = eff - ONE;
  assign wrap    = (phase_q == last);
  assign running = (state_q == RUNNING);

  // State, latched period and phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      phase_q  <= phase_d;
    end
  end

  // Next state: stop beats arm, arm beats a sync edge.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    phase_d  = phase_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            state_d  = ARMED;
            period_d = bus.period;
          end
        end
        ARMED: begin
          if (bus.arm) begin
            period_d = bus.period;
          end else if (rise) begin
            state_d = RUNNING;
            phase_d = '0;
          end
        end
        RUNNING: begin
          if (bus.arm) begin
            state_d  = ARMED;
            period_d = bus.period;
          end else begin
            phase_d = wrap ? '0 : phase_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sync_out  = running & (phase_q < PW_P);
  assign bus.count_en  = running;
  assign bus.count_rst = ~running | (phase_q == '0);
  assign bus.armed     = (state_q == ARMED);
  assign bus.running   = running;

`ifdef SYNC_GEN_PULSE_CNT_EN
  logic [PULSE_CNT_WIDTH-1:0] cnt_q;
  logic                       load;

  assign load = ~bus.stop & ~bus.arm &
                (((state_q == ARMED) & rise) |
                 (running & wrap));

  // Count every phase-zero load; arm starts afresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (bus.arm & ~bus.stop)
      cnt_q <= '0;
    else if (load)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.pulse_cnt = cnt_q;
`else
  assign bus.pulse_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_gen.sv
// Self-checking bench for sync_gen, two pulse widths in parallel.
// Optional pulse counter build macro: SYNC_GEN_PULSE_CNT_EN.
module tb_sync_gen;

  localparam int PW0 = 1;
  localparam int PW1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        stop;
  logic        sync_in;
  logic [15:0] period;

  always #5 clk = ~clk;

  sync_gen_if bus0 ();
  sync_gen_if bus1 ();

  assign bus0.arm     = arm;
  assign bus0.stop    = stop;
  assign bus0.sync_in = sync_in;
  assign bus0.period  = period;
  assign bus1.arm     = arm;
  assign bus1.stop    = stop;
  assign bus1.sync_in = sync_in;
  assign bus1.period  = period;

  sync_gen #(.PULSE_WIDTH(PW0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sync_gen #(.PULSE_WIDTH(PW1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 armed, 2 running.
  int          mode;
  int unsigned per;
  int unsigned t0;
  int unsigned cyc;
  int unsigned cnt [2];
  logic        sprev;

  function automatic int unsigned pw_of(int i);
    return (i == 0) ? PW0 : PW1;
  endfunction

  function automatic int unsigned eff_of(int i);
    int unsigned p;
    p = pw_of(i);
    return (per > p) ? per : p + 1;
  endfunction

  task automatic model_reset();
    mode   = 0;
    per    = 0;
    sprev  = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
  endtask

  task automatic model_edge();
    logic r;
    r     = sync_in & ~sprev;
    sprev = sync_in;
    cyc++;
    if (stop) begin
      mode = 0;
    end else if (arm) begin
      mode   = 1;
      per    = int'(period);
      cnt[0] = 0;
      cnt[1] = 0;
    end else if (mode == 1 && r) begin
      mode = 2;
      t0   = cyc;
      cnt[0]++;
      cnt[1]++;
    end else if (mode == 2) begin
      for (int i = 0; i < 2; i++)
        if ((cyc - t0) % eff_of(i) == 0) cnt[i]++;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_inst(int i, logic so, logic ce,
                            logic cr, logic ar, logic rn,
                            logic [31:0] pc);
    bit          r;
    int unsigned k;
    logic [31:0] ecnt;
    r = (mode == 2);
    k = r ? (cyc - t0) % eff_of(i) : 0;
`ifdef SYNC_GEN_PULSE_CNT_EN
    ecnt = cnt[i];
`else
    ecnt = 0;
`endif
    chk($sformatf("u%0d.sync_out@%0d", i, cyc),
        32'(so), 32'(r && k < pw_of(i)));
    chk($sformatf("u%0d.count_en@%0d", i, cyc),
        32'(ce), 32'(r));
    chk($sformatf("u%0d.count_rst@%0d", i, cyc),
        32'(cr), 32'(!r || k == 0));
    chk($sformatf("u%0d.armed@%0d", i, cyc),
        32'(ar), 32'(mode == 1));
    chk($sformatf("u%0d.running@%0d", i, cyc),
        32'(rn), 32'(r));
    chk($sformatf("u%0d.pulse_cnt@%0d", i, cyc),
        pc, ecnt);
  endtask

  task automatic check_all();
    check_inst(0, bus0.sync_out, bus0.count_en,
               bus0.count_rst, bus0.armed,
               bus0.running, bus0.pulse_cnt);
    check_inst(1, bus1.sync_out, bus1.count_en,
               bus1.count_rst, bus1.armed,
               bus1.running, bus1.pulse_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    arm     = 1'b0;
    stop    = 1'b0;
    sync_in = 1'b0;
    period  = '0;
    cyc     = 0;
    t0      = 0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // idle traffic is ignored
    repeat (6) begin
      sync_in = ~sync_in;
      tick();
    end
    sync_in = 1'b0;

    // basic lock, period 8
    period = 16'd8;
    arm    = 1'b1;
    tick();
    arm = 1'b0;
    ticks(8);
    sync_in = 1'b1;
    ticks(20);
    repeat (6) begin
      sync_in = ~sync_in;
      tick();
    end

    // clamp: period 0
    stop = 1'b1;
    tick();
    stop    = 1'b0;
    period  = 16'd0;
    arm     = 1'b1;
    sync_in = 1'b0;
    tick();
    arm = 1'b0;
    tick();
    sync_in = 1'b1;
    ticks(12);

    // arm and rise together while armed
    sync_in = 1'b0;
    period  = 16'd6;
    arm     = 1'b1;
    tick();
    sync_in = 1'b1;
    tick();
    arm = 1'b0;
    ticks(3);
    sync_in = 1'b0;
    tick();
    sync_in = 1'b1;
    ticks(14);

    // arm mid-pulse with period 5, then relock
    stop = 1'b1;
    tick();
    stop    = 1'b0;
    sync_in = 1'b0;
    period  = 16'd6;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    sync_in = 1'b1;
    ticks(2);
    period = 16'd5;
    arm    = 1'b1;
    tick();
    arm     = 1'b0;
    sync_in = 1'b0;
    tick();
    sync_in = 1'b1;
    ticks(12);

    // stop beats arm
    stop = 1'b1;
    arm  = 1'b1;
    tick();
    stop = 1'b0;
    arm  = 1'b0;
    repeat (4) begin
      sync_in = ~sync_in;
      tick();
    end

    // async reset mid-run
    sync_in = 1'b0;
    period  = 16'd4;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    sync_in = 1'b1;
    ticks(3);
    async_reset();

    // three pulses after reset
    sync_in = 1'b0;
    period  = 16'd4;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    sync_in = 1'b1;
    ticks(9);

    // randomized traffic
    repeat (600) begin
      arm  = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        sync_in = ~sync_in;
      period = 16'($urandom_range(0, 12));
      tick();
    end
    arm  = 1'b0;
    stop = 1'b0;
    ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_gen.md
Name: sync_gen

Overview:
Periodic sync-pulse generator that sits directly upstream of the team's free-running counter primitive.
- Once armed, it locks to the first rising edge of an external sync input.
- It then emits a periodic sync pulse train.
- It drives the downstream counter's enable and (active-high) reset so the count phase-aligns to each sync period.

Parameters:
ARCHITECTURE, "BEHAVIORAL", implementation select; only "BEHAVIORAL" is populated, "VIRTEX5"/"VIRTEX6" are empty placeholders.
PERIOD_WIDTH, 16, width of the period input and internal phase counter.
PULSE_WIDTH, 1, cycles sync_out stays high per period; legal range 1..2^PERIOD_WIDTH-2.
PULSE_CNT_WIDTH, 32, width of pulse_cnt (optional feature only).

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
arm  in  1  1-cycle request: latch period, wait for sync_in rising edge.
stop  in  1  return to IDLE.
sync_in  in  1  external sync, synchronous to clk.
period  in  PERIOD_WIDTH  sync period in clk cycles; sampled only on arm.
sync_out  out  1  periodic sync pulse.
count_en  out  1  enable to downstream counter.
count_rst  out  1  active-high reset to downstream counter.
armed  out  1  status: state == ARMED.
running  out  1  status: state == RUNNING.
pulse_cnt  out  PULSE_CNT_WIDTH  emitted-pulse count (optional feature).

Behaviour:
- Registers: state, period_q, phase[PERIOD_WIDTH-1:0], sync_d (previous sync_in sample).
- All outputs decode from registers only; no combinational path from inputs to outputs.
- rst=0 clears asynchronously, including mid-operation: state=IDLE, period_q=0, phase=0, sync_d=0. Resulting outputs: sync_out=0, count_en=0, count_rst=1, armed=0, running=0, pulse_cnt=0.
- eff_period = max(period_q, PULSE_WIDTH+1). Period values 0..PULSE_WIDTH are therefore clamped.
- rise = sync_in & ~sync_d; sync_d <= sync_in every cycle.
- IDLE:
  - arm -> ARMED, period_q <= period.
  - rise is ignored.
- ARMED:
  - arm -> stay ARMED, period_q re-latched.
  - rise with no arm -> RUNNING, phase <= 0.
  - arm and rise in the same cycle: arm wins (stay ARMED, edge dropped).
- RUNNING:
  - Each cycle phase <= (phase == eff_period-1) ? 0 : phase+1. Wraps cleanly; no overflow.
  - Further sync_in edges are ignored (free-running).
  - arm -> ARMED, period_q <= period.
- stop in any state -> IDLE next edge. stop beats arm when both are asserted.
- Output decode:
  - sync_out = running & (phase < PULSE_WIDTH).
  - count_en = running.
  - count_rst = ~running | (phase == 0).
  - armed/running = state decode.
- Latency: sync_in sampled 1 (after 0) at edge k -> sync_out high from edge k for PULSE_WIDTH cycles. Next pulse starts at edge k + eff_period.
- Leaving RUNNING (arm/stop) drops sync_out/count_en at the transition edge, even mid-pulse.

Optional Feature:
SYNC_GEN_PULSE_CNT_EN
- Defined: pulse_cnt increments (wrapping at 2^PULSE_CNT_WIDTH) on each edge that loads phase <= 0 in/into RUNNING. It clears on rst and on arm; stop holds the value.
- Undefined: no counter logic is built; port exists, tied to 0.

Decomposition:
- sync_gen_pkg holds:
  - state typedef: IDLE=2'b00, ARMED=2'b01, RUNNING=2'b10; 2'b11 recovers to IDLE.
  - eff_period clamp function.
- One natural sub-module: edge_detect (registered rising-edge detector, same clk/rst convention), instantiated for sync_in.

Test Plan:
- Reset defaults, then idle traffic: rst=0 -> sync_out=0, count_en=0, count_rst=1, armed=0, running=0. Release rst, toggle sync_in with no arm -> outputs unchanged.
- Basic lock: period=8, PULSE_WIDTH=1, arm, then sync_in rises at edge 10 -> sync_out high in cycles 10, 18, 26. count_rst high in the same cycles; count_en high from 10.
- Clamp: period=0, PULSE_WIDTH=3 -> eff_period=4. sync_out pattern 1,1,1,0 repeating.
- Arm and rise in the same cycle while ARMED -> stays ARMED, no sync_out. The next rise locks.
- Mid-run control:
  - arm during pulse with period=5 -> sync_out/count_en drop next edge, armed=1. Next rise relocks at period 5.
  - stop+arm together -> IDLE.
- Async reset mid-RUNNING, asserted between clock edges -> outputs reach reset values immediately. With SYNC_GEN_PULSE_CNT_EN, pulse_cnt = 0; after 3 pulses, pulse_cnt=3.
